// File: rtl/hyperram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hyperram_pkg
// Purpose  : Shared definitions for the HyperRAM device-side responder:
//            FSM state encoding, command/address bit positions, CA length,
//            counter width and the default register-space ID value.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package hyperram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CA   = 3'd1,
    ST_LAT  = 3'd2,
    ST_WR   = 3'd3,
    ST_RD   = 3'd4,
    ST_HOLD = 3'd5
  } state_e;

  localparam int CA_RW_BIT    = 47;  // 1 = read, 0 = write
  localparam int CA_AS_BIT    = 46;  // 1 = register space
  localparam int CA_BURST_BIT = 45;  // 1 = linear burst, 0 = wrapped (unsupported)
  localparam int CA_BYTES     = 6;

  // Shared by the CA byte counter and the latency edge counter (up to 32 edges).
  localparam int CNT_W = 6;

  localparam logic [15:0] REG_ID_DEFAULT = 16'h0C81;

endpackage
`default_nettype wire

// File: rtl/hyperram_resp_mem.sv
`default_nettype none
// ============================================================================
// Module   : hyperram_resp_mem
// Purpose  : 2^ADDR_W x 16 halfword RAM with independent high/low byte write
//            enables and one registered read port. No reset: contents are
//            undefined at power-up and untouched by rst.
// Ports    : clk        - clock
//            we_hi_i    - write wdata_i into bits [15:8] of waddr_i
//            we_lo_i    - write wdata_i into bits [7:0]  of waddr_i
//            waddr_i    - write halfword address
//            wdata_i    - write byte (same byte feeds both lanes)
//            raddr_i    - read halfword address
//            rdata_o    - registered read data, mem[raddr_i] one clk later
// Revision : 1.0 - initial release
// ============================================================================
module hyperram_resp_mem #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we_hi_i,
  input  logic              we_lo_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [15:0]       rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [15:0] mem_q [DEPTH];
  logic [15:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_hi_i) mem_q[waddr_i][15:8] <= wdata_i;
    if (we_lo_i) mem_q[waddr_i][7:0]  <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/hyperram_responder.sv
`default_nettype none
// ============================================================================
// Module   : hyperram_responder
// Purpose  : Cycle-deterministic HyperRAM device model. Decodes the 48-bit
//            CA phase, waits a fixed initial latency, then stores masked
//            write bytes or streams read bytes back with an RWDS strobe.
// Ports    : clk, rst   - system clock, synchronous active-high reset
//            cs_n       - chip select from controller (active low)
//            ck         - controller ck level; each change is one edge
//            dq_in      - bus byte from controller
//            rwds_in    - write byte mask (1 = masked)
//            dq_out     - read byte to controller
//            dq_oe      - responder drives dq
//            rwds_out   - read strobe / latency indicator
//            rwds_oe    - responder drives rwds
//            busy       - registered, high whenever not idle
// Revision : 1.0 - initial release
// ============================================================================
module hyperram_responder
  import hyperram_pkg::*;
#(
  parameter int          ADDR_W  = 8,
  parameter int          LATENCY = 6,
  parameter logic [15:0] REG_ID  = REG_ID_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic       ck,
  input  logic [7:0] dq_in,
  input  logic       rwds_in,
  output logic [7:0] dq_out,
  output logic       dq_oe,
  output logic       rwds_out,
  output logic       rwds_oe,
  output logic       busy
);

  localparam logic [CNT_W-1:0] LAST_CA  = CNT_W'(CA_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST_LAT = CNT_W'(2 * LATENCY - 1);

  state_e              state_q, state_d;
  logic                ck_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [39:0]         ca_q, ca_d;      // first five CA bytes; sixth taken live
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          lo_q, lo_d;      // low byte parked while next word is fetched
  logic                sel_q, sel_d;    // 0 = next byte is high, 1 = next is low
  logic                is_rd_q, is_rd_d;
  logic                is_reg_q, is_reg_d;
  logic [7:0]          dq_out_q, dq_out_d;
  logic                dq_oe_q, dq_oe_d;
  logic                rwds_out_q, rwds_out_d;
  logic                rwds_oe_q, rwds_oe_d;
  logic                busy_q;

  logic                w_edge;
  logic [47:0]         w_ca_full;
  logic [31:0]         w_ca_addr;
  logic [15:0]         w_mem_rdata;
  logic [15:0]         w_word;
  logic                w_we_hi, w_we_lo;
  logic                w_emit_hi;
  logic                w_unused;

  assign w_edge    = (ck ^ ck_q) & ~cs_n;
  assign w_ca_full = {ca_q, dq_in};
  assign w_ca_addr = {w_ca_full[44:16], w_ca_full[2:0]};
  assign w_word    = is_reg_q ? REG_ID : w_mem_rdata;
  assign w_unused  = &{1'b0, w_ca_full[15:3], w_ca_addr};

  hyperram_resp_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_hi_i (w_we_hi),
    .we_lo_i (w_we_lo),
    .waddr_i (addr_q),
    .wdata_i (dq_in),
    .raddr_i (addr_q),
    .rdata_o (w_mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ck_q       <= 1'b0;
      cnt_q      <= '0;
      ca_q       <= '0;
      addr_q     <= '0;
      lo_q       <= '0;
      sel_q      <= 1'b0;
      is_rd_q    <= 1'b0;
      is_reg_q   <= 1'b0;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      rwds_out_q <= 1'b0;
      rwds_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ck_q       <= ck;
      cnt_q      <= cnt_d;
      ca_q       <= ca_d;
      addr_q     <= addr_d;
      lo_q       <= lo_d;
      sel_q      <= sel_d;
      is_rd_q    <= is_rd_d;
      is_reg_q   <= is_reg_d;
      dq_out_q   <= dq_out_d;
      dq_oe_q    <= dq_oe_d;
      rwds_out_q <= rwds_out_d;
      rwds_oe_q  <= rwds_oe_d;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ca_d       = ca_q;
    addr_d     = addr_q;
    lo_d       = lo_q;
    sel_d      = sel_q;
    is_rd_d    = is_rd_q;
    is_reg_d   = is_reg_q;
    dq_out_d   = dq_out_q;
    rwds_out_d = rwds_out_q;
    w_we_hi    = 1'b0;
    w_we_lo    = 1'b0;
    w_emit_hi  = 1'b0;

    if (cs_n) begin
      // Deselect beats any edge in the same clk: edge is already gated by cs_n.
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_CA;
          cnt_d   = '0;
        end
        ST_CA: begin
          if (w_edge) begin
            ca_d = w_ca_full[39:0];
            if (cnt_q == LAST_CA) begin
              cnt_d    = '0;
              sel_d    = 1'b0;
              is_rd_d  = w_ca_full[CA_RW_BIT];
              is_reg_d = w_ca_full[CA_AS_BIT];
              addr_d   = w_ca_addr[ADDR_W-1:0];
              if (!w_ca_full[CA_BURST_BIT]) begin
                state_d = ST_HOLD;
              end else if (!w_ca_full[CA_RW_BIT] && w_ca_full[CA_AS_BIT]) begin
                state_d = ST_WR;  // register write: zero latency, data dropped
              end else begin
                state_d = ST_LAT;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_LAT: begin
          if (w_edge) begin
            if (cnt_q == LAST_LAT) begin
              cnt_d = '0;
              sel_d = 1'b0;
              if (is_rd_q) begin
                state_d   = ST_RD;
                w_emit_hi = 1'b1;  // last latency edge already carries byte 0
              end else begin
                state_d = ST_WR;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_WR: begin
          if (w_edge) begin
            if (!is_reg_q) begin
              w_we_hi = ~sel_q & ~rwds_in;
              w_we_lo =  sel_q & ~rwds_in;
            end
            if (sel_q) addr_d = addr_q + ADDR_W'(1);
            sel_d = ~sel_q;
          end
        end
        ST_RD: begin
          if (w_edge) begin
            if (sel_q) begin
              dq_out_d   = lo_q;
              rwds_out_d = 1'b0;
              sel_d      = 1'b0;
            end else begin
              w_emit_hi = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          state_d = ST_HOLD;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // High byte goes out now; the address advances immediately so the
    // registered RAM output holds the next word by the following high byte
    // even when edges arrive on back-to-back clks.
    if (w_emit_hi) begin
      dq_out_d   = w_word[15:8];
      lo_d       = w_word[7:0];
      rwds_out_d = 1'b1;
      addr_d     = addr_q + ADDR_W'(1);
      sel_d      = 1'b1;
    end

    if (state_d != ST_RD) begin
      dq_out_d   = '0;
      rwds_out_d = 1'b0;
    end
    dq_oe_d   = (state_d == ST_RD);
    rwds_oe_d = (state_d == ST_CA) || (state_d == ST_RD);
  end

  assign dq_out   = dq_out_q;
  assign dq_oe    = dq_oe_q;
  assign rwds_out = rwds_out_q;
  assign rwds_oe  = rwds_oe_q;
  assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_hyperram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_hyperram_responder
// Purpose  : Self-checking bench for hyperram_responder. A halfword array
//            with per-byte valid flags models the device memory; CA decode,
//            latency and byte ordering are computed arithmetically here.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_hyperram_responder;

  localparam int ADDR_W  = 8;
  localparam int LATENCY = 6;
  localparam int DEPTH   = 256;
  localparam logic [15:0] REG_ID = 16'h0C81;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n = 1'b1;
  logic       ck = 1'b0;
  logic [7:0] dq_in = '0;
  logic       rwds_in = 1'b0;
  logic [7:0] dq_out;
  logic       dq_oe;
  logic       rwds_out;
  logic       rwds_oe;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mdl [DEPTH];
  bit          vhi [DEPTH];
  bit          vlo [DEPTH];
  logic [7:0]  wbuf [16];
  bit          mbuf [16];

  hyperram_responder #(
    .ADDR_W  (ADDR_W),
    .LATENCY (LATENCY),
    .REG_ID  (REG_ID)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cs_n     (cs_n),
    .ck       (ck),
    .dq_in    (dq_in),
    .rwds_in  (rwds_in),
    .dq_out   (dq_out),
    .dq_oe    (dq_oe),
    .rwds_out (rwds_out),
    .rwds_oe  (rwds_oe),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One ck transition, optionally preceded by idle clks.
  task automatic ck_edge();
    repeat ($urandom_range(0, 1)) step();
    ck = ~ck;
    step();
  endtask

  function automatic int ca_addr(input logic [47:0] ca);
    longint unsigned hi, lo;
    hi = longint'((ca >> 16) & 48'h1FFF_FFFF);
    lo = longint'(ca & 48'h7);
    return int'((hi * 8 + lo) % DEPTH);
  endfunction

  function automatic logic [47:0] ca_of(input int a, input bit rd, input bit rs);
    logic [47:0] c;
    c = 48'h2000_0000_0000;  // linear burst
    c[47] = rd;
    c[46] = rs;
    c = c | (48'(a / 8) << 16) | 48'(a % 8);
    return c;
  endfunction

  task automatic start();
    cs_n = 1'b0;
    step();
    check("busy_rise", busy, 1);
  endtask

  task automatic end_burst();
    cs_n    = 1'b1;
    rwds_in = 1'b0;
    step();
    check("busy_fall", busy, 0);
    step();
  endtask

  task automatic send_ca(input logic [47:0] ca, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      logic [47:0] t;
      t = ca >> (8 * (5 - i));
      dq_in = t[7:0];
      ck_edge();
      if (i == 0) begin
        check("ca_rwds_oe", rwds_oe, 1);
        check("ca_rwds_out", rwds_out, 0);
      end
    end
  endtask

  task automatic wr_burst(input logic [47:0] ca, input int n);
    int a;
    bit rs;
    a  = ca_addr(ca);
    rs = ca[46];
    start();
    send_ca(ca, 6);
    if (!rs) repeat (2 * LATENCY) ck_edge();
    for (int k = 0; k < n; k++) begin
      int h;
      dq_in   = wbuf[k];
      rwds_in = mbuf[k];
      ck_edge();
      h = (a + k / 2) % DEPTH;
      if (!rs && !mbuf[k]) begin
        if (k % 2 == 0) begin mdl[h][15:8] = wbuf[k]; vhi[h] = 1'b1; end
        else            begin mdl[h][7:0]  = wbuf[k]; vlo[h] = 1'b1; end
      end
    end
    end_burst();
  endtask

  // Reads n bytes; leaves cs_n low when keep is set.
  task automatic rd_burst(input logic [47:0] ca, input int n, input bit keep);
    int a;
    bit rs;
    a  = ca_addr(ca);
    rs = ca[46];
    start();
    send_ca(ca, 6);
    check("lat_rwds_oe", rwds_oe, 0);
    repeat (2 * LATENCY - 1) ck_edge();
    check("lat_dq_oe", dq_oe, 0);
    ck_edge();
    for (int k = 0; k < n; k++) begin
      int h;
      logic [7:0] exp;
      if (k > 0) ck_edge();
      h = (a + k / 2) % DEPTH;
      if (rs) exp = (k % 2 == 0) ? REG_ID[15:8] : REG_ID[7:0];
      else    exp = (k % 2 == 0) ? mdl[h][15:8] : mdl[h][7:0];
      if (rs || ((k % 2 == 0) ? vhi[h] : vlo[h])) check("rd_dq", dq_out, exp);
      check("rd_rwds", rwds_out, (k % 2 == 0) ? 1 : 0);
      check("rd_dq_oe", dq_oe, 1);
      check("rd_rwds_oe", rwds_oe, 1);
    end
    if (!keep) end_burst();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin vhi[i] = 1'b0; vlo[i] = 1'b0; mdl[i] = '0; end
    for (int i = 0; i < 16; i++) mbuf[i] = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_dq_out", dq_out, 0);
    check("rst_dq_oe", dq_oe, 0);
    check("rst_rwds_out", rwds_out, 0);
    check("rst_rwds_oe", rwds_oe, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    step();

    // Basic write / read at halfword 1 (CA[45] set for linear burst)
    wbuf[0] = 8'hAA; wbuf[1] = 8'h55; wbuf[2] = 8'hBB; wbuf[3] = 8'h66;
    wr_burst(48'h2000_0000_0001, 4);
    rd_burst(48'hA000_0000_0001, 4, 1'b0);

    // Masked write: second byte masked
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; mbuf[1] = 1'b1;
    wr_burst(48'h2000_0000_0001, 2);
    mbuf[1] = 1'b0;
    rd_burst(48'hA000_0000_0001, 4, 1'b0);

    // Wrap from last halfword to 0
    wbuf[0] = 8'h12; wbuf[1] = 8'h34; wbuf[2] = 8'h56; wbuf[3] = 8'h78;
    wr_burst(ca_of(255, 1'b0, 1'b0), 4);
    rd_burst(ca_of(255, 1'b1, 1'b0), 4, 1'b0);

    // Abort after three CA bytes
    start();
    send_ca(48'h2000_0000_0001, 3);
    cs_n = 1'b1;
    step();
    check("abort_busy", busy, 0);
    check("abort_rwds_oe", rwds_oe, 0);
    step();
    rd_burst(48'hA000_0000_0001, 2, 1'b0);

    // Register read returns REG_ID repeatedly
    rd_burst(48'hE000_0000_0000, 6, 1'b0);

    // Register write discards data; halfword 0 must be untouched
    wbuf[0] = 8'hDE; wbuf[1] = 8'hAD; wbuf[2] = 8'hBE; wbuf[3] = 8'hEF;
    wr_burst(48'h6000_0000_0000, 4);
    rd_burst(ca_of(0, 1'b1, 1'b0), 2, 1'b0);

    // Wrapped-burst CA is illegal: responder parks and ignores edges
    start();
    send_ca(48'h0000_0000_0001, 6);
    dq_in = 8'hC3;
    repeat (2 * LATENCY + 4) ck_edge();
    check("hold_busy", busy, 1);
    check("hold_dq_oe", dq_oe, 0);
    check("hold_rwds_oe", rwds_oe, 0);
    end_burst();
    rd_burst(48'hA000_0000_0001, 2, 1'b0);

    // Randomized bursts
    for (int it = 0; it < 16; it++) begin
      int a, n;
      a = $urandom_range(0, DEPTH - 1);
      n = $urandom_range(1, 10);
      for (int k = 0; k < n; k++) begin
        wbuf[k] = 8'($urandom);
        mbuf[k] = ($urandom_range(0, 3) == 0);
      end
      wr_burst(ca_of(a, 1'b0, 1'b0), n);
      rd_burst(ca_of(a, 1'b1, 1'b0), n, 1'b0);
      for (int k = 0; k < n; k++) mbuf[k] = 1'b0;
    end

    // Reset in the middle of a read
    rd_burst(48'hA000_0000_0001, 2, 1'b1);
    rst = 1'b1;
    step();
    check("mid_rst_dq_out", dq_out, 0);
    check("mid_rst_dq_oe", dq_oe, 0);
    check("mid_rst_rwds_out", rwds_out, 0);
    check("mid_rst_rwds_oe", rwds_oe, 0);
    check("mid_rst_busy", busy, 0);
    cs_n = 1'b1;
    rst  = 1'b0;
    step();
    wbuf[0] = 8'h9A; wbuf[1] = 8'hBC;
    wr_burst(ca_of(7, 1'b0, 1'b0), 2);
    rd_burst(ca_of(7, 1'b1, 1'b0), 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
